// File: rtl/pe_drain.sv
// Drains WORDS accumulator words from a row of N PEs into a DEPTH-beat output FIFO.
// Optional back-pressure counter enabled by defining PE_DRAIN_STALL_CNT_EN.
module pe_drain #(
  parameter int N     = 4,
  parameter int WORDS = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              wben,
  output logic              out_ready,
  input  logic [32*N-1:0]   pe_sum,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [32*N-1:0]   m_data,
  output logic              m_last,
  output logic [15:0]       stall_cnt
);

  localparam int DATA_W = 32 * N;
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = PW + 1;
  localparam int IW     = $clog2(WORDS + 1);

  localparam logic [IW-1:0] WORDS_C = IW'(WORDS);
  localparam logic [IW-1:0] LAST_C  = IW'(WORDS - 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   issued_q, issued_d;
  logic [IW-1:0]   popped_q, popped_d;
  logic            inflight_q, inflight_d;
  logic            last_seen_q, last_seen_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DATA_W-1:0] fifo_mem [DEPTH];

  logic push;
  logic pop;
  logic start_acc;
  logic [CW:0] credit_used;

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    popped_d    = popped_q;
    last_seen_d = last_seen_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    start_acc   = (state_q == IDLE) && start;
    busy        = (state_q != IDLE);
    wben        = (state_q == DRAIN);

    // A word is only requested when a FIFO slot is guaranteed for it,
    // counting the word already on its way from the PE register.
    credit_used = {1'b0, count_q} + (CW + 1)'(inflight_q);
    out_ready   = (state_q == DRAIN) && (issued_q < WORDS_C) && (credit_used < DEPTH_C);
    inflight_d  = out_ready;

    m_valid     = (count_q != '0);
    m_last      = m_valid && (popped_q == LAST_C);
    pop         = m_valid && m_ready;
    push        = inflight_q;
    done        = (state_q == WAIT) && !inflight_q && (count_q == '0) && last_seen_q;

    if (out_ready) begin
      issued_d = issued_q + IW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      popped_d = popped_q + IW'(1);
      if (m_last) begin
        last_seen_d = 1'b1;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = DRAIN;
          issued_d    = '0;
          popped_d    = '0;
          last_seen_d = 1'b0;
        end
      end
      DRAIN: begin
        if (issued_q == WORDS_C) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issued_q    <= '0;
      popped_q    <= '0;
      inflight_q  <= 1'b0;
      last_seen_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      popped_q    <= popped_d;
      inflight_q  <= inflight_d;
      last_seen_q <= last_seen_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage: PE out_sum is registered, so capture lags out_ready by one cycle
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= pe_sum;
    end
  end

  assign m_data = m_valid ? fifo_mem[rd_ptr_q] : '0;

`ifdef PE_DRAIN_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (busy && m_valid && !m_ready) begin
      stall_d = sat_inc16(stall_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
